// File: rtl/lenet_pkg.sv
// lenet_pkg: shared pixel/image types and frame geometry for the LeNet front end
package lenet_pkg;
    localparam int DATA_W = 16;
    localparam int IMG_DIM = 28;
    localparam int POS_W = $clog2(IMG_DIM);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(IMG_DIM - 1);

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef pixel_t [IMG_DIM-1:0][IMG_DIM-1:0] image_t;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;

    // True when (row, col) addresses the last pixel of a raster frame
    function automatic logic is_final(input logic [POS_W-1:0] row, input logic [POS_W-1:0] col);
        return row == LAST_POS && col == LAST_POS;
    endfunction
endpackage

// File: rtl/image_bank.sv
// image_bank: one IMG_DIM x IMG_DIM pixel register array, single write port, full parallel read
module image_bank
    import lenet_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      we,
    input  logic [POS_W-1:0]                          row,
    input  logic [POS_W-1:0]                          col,
    input  logic [DATA_W-1:0]                         din,
    output logic [IMG_DIM-1:0][IMG_DIM-1:0][DATA_W-1:0] dout
);
    image_t mem_q, mem_d;

    // Write the addressed pixel; all other pixels hold
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[row][col] = din;
    end

    // Pixel storage is deliberately not reset; contents are only meaningful once a bank is FULL
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q;
endmodule

// File: rtl/image_frame_loader.sv
// image_frame_loader: raster pixel stream to ping-pong buffered parallel image for the accelerator
module image_frame_loader
    import lenet_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [DATA_W-1:0]                         s_pixel,
    input  logic                                      s_valid,
    input  logic                                      s_last,
    output logic                                      s_ready,
    output logic [IMG_DIM-1:0][IMG_DIM-1:0][DATA_W-1:0] image,
    output logic                                      frame_valid,
    input  logic                                      frame_ack,
    output logic                                      frame_err,
    output logic [CNT_W-1:0]                          frame_count
);
    bank_state_e st_q [2];
    bank_state_e st_d [2];
    logic wr_q, wr_d, rd_q, rd_d, run_q, run_d, err_q, err_d;
    logic [POS_W-1:0] row_q, row_d, col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic beat, good, bad, ack;
    logic [1:0] we;
    logic [IMG_DIM-1:0][IMG_DIM-1:0][DATA_W-1:0] bank_img [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        image_bank u_bank (
            .clk (clk),
            .we  (we[b]),
            .row (row_q),
            .col (col_q),
            .din (s_pixel),
            .dout(bank_img[b])
        );
    end

    // State registers; run_q holds s_ready low during the reset cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0] <= EMPTY;
            st_q[1] <= EMPTY;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            run_q   <= run_d;
            err_q   <= err_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake events; a bank under write is never the FULL bank being presented
    always_comb begin
        beat = s_valid && s_ready;
        good = beat && s_last && is_final(row_q, col_q);
        bad  = beat && (s_last != is_final(row_q, col_q));
        ack  = frame_ack && frame_valid;
        we   = {beat && wr_q, beat && !wr_q};
    end

    // Bank state next-state: ack frees the read bank, beats advance the write bank
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i] = st_q[i];
            if (ack && rd_q == 1'(i)) st_d[i] = EMPTY;
            if (we[i]) st_d[i] = good ? FULL : bad ? EMPTY : FILLING;
        end
    end

    // Raster position, bank pointers, frame counter and error pulse
    always_comb begin
        run_d = 1'b1;
        err_d = bad;
        wr_d  = wr_q ^ good;
        rd_d  = rd_q ^ ack;
        cnt_d = cnt_q + CNT_W'(good);
        row_d = (good || bad) ? '0 : (beat && col_q == LAST_POS) ? row_q + 1'b1 : row_q;
        col_d = (good || bad || (beat && col_q == LAST_POS)) ? '0 : beat ? col_q + 1'b1 : col_q;
    end

    // Outputs: backpressure when the write bank is FULL, present the read bank
    always_comb begin
        s_ready     = run_q && st_q[wr_q] != FULL;
        frame_valid = st_q[rd_q] == FULL;
        image       = bank_img[rd_q];
        frame_err   = err_q;
        frame_count = cnt_q;
    end
endmodule
